cardinal_nic: RTL and testbench
===============================

# cardinal_nic

Network interface controller between one processing element (PE) and the PE port of its mesh router. Each direction has a one-entry 64-bit packet buffer. The PE side is a small memory-mapped register file. The router side uses the router's send/ready channel handshake. Outbound packets are released only when their virtual-channel bit matches the router's polarity, so the even and odd channels stay aligned with the router's even/odd arbitration.

## Interface
Parameters:
- DATA_WIDTH, 64, packet width; bit DATA_WIDTH-1 is the virtual-channel (VC) bit; must be ≥ 8

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- addr  input  2  PE register address: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status
- d_in  input  DATA_WIDTH  PE write data
- d_out  output  DATA_WIDTH  PE read data
- nic_en  input  1  PE access enable
- nic_wr_en  input  1  1 = write, 0 = read; qualified by nic_en
- net_polarity  input  1  router polarity (0 = even cycle, 1 = odd cycle)
- net_si  input  1  router-to-NIC send
- net_ri  output  1  NIC ready to accept from router
- net_di  input  DATA_WIDTH  router-to-NIC data
- net_so  output  1  NIC-to-router send
- net_ro  input  1  router ready to accept from NIC
- net_do  output  DATA_WIDTH  NIC-to-router data

## Operation

**State held**
- in_buf with in_full; out_buf with out_full.
- Sticky flags in_ovf and out_ovf.
- 8-bit wrapping counters tx_cnt and rx_cnt.

**Reset (reset = 0, asynchronous)**
- All buffers, flags and counters clear to 0.
- Resulting outputs: net_ri = 1, net_so = 0, net_do = 0, d_out = 0.
- A reset asserted mid-operation discards any buffered packets.

**Inbound path (router to PE)**
- net_ri = ~in_full.
- Capture: at an edge with net_si = 1 and net_ri = 1, in_buf <= net_di, in_full <= 1, rx_cnt increments.
- net_si while full: no capture, in_ovf <= 1, incoming data ignored.

**Outbound path (PE to router)**
- net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity).
- net_do = out_buf while out_full, else 0.
- Release: at an edge with net_so = 1, out_full <= 0 and tx_cnt increments.

**PE accesses (only when nic_en = 1)**
- Write to addr 2:
  - If out_full = 0 before the edge, out_buf <= d_in and out_full <= 1.
  - Otherwise the write is dropped and out_ovf <= 1. This includes the cycle in which the buffer is being released.
- Writes to addr 0, 1 and 3 are ignored.
- Read of addr 0: d_out = in_buf, and in_full clears at the edge. If in_full = 0, d_out = 0 and no state change.
- Read of addr 1: d_out = {rx_cnt in bits [15:8], in_ovf in bit 1, in_full in bit 0}, zero elsewhere. Clears in_ovf at the edge.
- Read of addr 3: d_out = {tx_cnt in bits [15:8], out_ovf in bit 1, out_full in bit 0}, zero elsewhere. Clears out_ovf at the edge.
- With nic_en = 0 or nic_wr_en = 1, d_out = 0.

**Simultaneous events**
- A status read and a new overflow in the same cycle: the flag stays 1 (set wins over clear).
- A PE read of addr 0 and a router send in the same cycle: the send is refused because net_ri = 0. The flow-through path is deliberately absent.

**Arithmetic**
- Counters are 8-bit unsigned and wrap 255 -> 0.

## Timing
- d_out, net_ri, net_so and net_do are combinational from registered state plus the current inputs. There are no combinational paths from d_in or net_di.
- Latency, router to PE: a packet captured at edge N is readable from cycle N+1.
- Latency, PE to router: a PE write at edge N can drive net_so from cycle N+1.
- net_so asserts only in cycles where net_polarity equals the packet's VC bit. The earliest send therefore lands on the first matching polarity cycle with net_ro = 1.
- Back-to-back throughput is one packet per two cycles per direction, because of the clear-then-refill of the single-entry buffer.

## Test plan
- **Reset:** drive reset low mid-transfer with out_full = 1 -> asynchronously net_so = 0, net_ri = 1, and both status reads return 0.
- **Inbound:** router sends 0x0123_4567_89AB_CDEF -> net_ri drops next cycle. Read addr 1 -> 0x0101. Read addr 0 -> 0x0123_4567_89AB_CDEF. net_ri returns to 1 the cycle after.
- **Outbound VC gating:** PE writes 0x8000_0000_0000_00AA (VC = 1) while polarity toggles and net_ro = 1 -> net_so is high only in the first cycle with net_polarity = 1, net_do = 0x8000_0000_0000_00AA, and the tx_cnt field of status 3 reads 1.
- **Backpressure:** net_ro = 0 for 5 cycles with out_full = 1 -> net_so stays 0 and the packet is held. A second PE write -> out_ovf = 1; read addr 3 -> 0x0003, and a second read -> 0x0001.
- **Inbound overflow:** router asserts net_si while in_full = 1 -> in_buf is unchanged, in_ovf = 1, rx_cnt is unchanged.
- **Counter wrap:** 256 packets pass each direction -> tx_cnt and rx_cnt both read 0. Packet 257 -> both read 1.

Source files
------------

// File: rtl/cardinal_nic.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cardinal_nic
// Network interface controller between one processing element (PE) and the PE
// port of its mesh router. Each direction holds a single packet. The PE side
// is a four-entry memory-mapped register file. The router side uses a
// send/ready handshake, and outbound packets leave only on cycles where their
// virtual-channel bit (MSB) matches the router polarity.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   addr          PE register address (0 in buf, 1 in status, 2 out buf, 3 out status)
//   d_in / d_out  PE write data / PE read data (read data is combinational)
//   nic_en        PE access enable
//   nic_wr_en     1 = write, 0 = read (qualified by nic_en)
//   net_polarity  router even/odd cycle indicator
//   net_si/net_ri/net_di  router-to-NIC send, ready, data
//   net_so/net_ro/net_do  NIC-to-router send, ready, data
// -----------------------------------------------------------------------------
module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nic_en,
  input  logic                  nic_wr_en,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do
);

  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  in_full_q,  in_full_d;
  logic                  out_full_q, out_full_d;
  logic                  in_ovf_q,   in_ovf_d;
  logic                  out_ovf_q,  out_ovf_d;
  logic [7:0]            tx_cnt_q,   tx_cnt_d;
  logic [7:0]            rx_cnt_q,   rx_cnt_d;

  logic pe_rd_s;
  logic pe_wr_s;

  // Status word: counter in bits [15:8], overflow in bit 1, full in bit 0.
  function automatic logic [DATA_WIDTH-1:0] status_word(input logic [7:0] cnt,
                                                        input logic       ovf,
                                                        input logic       full);
    logic [DATA_WIDTH-1:0] w;
    w    = '0;
    w[0] = full;
    w[1] = ovf;
    for (int i = 0; i < 8; i++) begin
      if (i + 8 < DATA_WIDTH) begin
        w[i+8] = cnt[i];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Router-facing handshake outputs and PE read mux.
  always_comb begin
    pe_rd_s = nic_en & ~nic_wr_en;
    pe_wr_s = nic_en &  nic_wr_en;
    net_ri  = ~in_full_q;
    net_so  = out_full_q & net_ro & (out_buf_q[DATA_WIDTH-1] == net_polarity);
    net_do  = out_full_q ? out_buf_q : '0;
    d_out   = '0;
    if (pe_rd_s) begin
      case (addr)
        2'd0:    d_out = in_full_q ? in_buf_q : '0;
        2'd1:    d_out = status_word(rx_cnt_q, in_ovf_q, in_full_q);
        2'd3:    d_out = status_word(tx_cnt_q, out_ovf_q, out_full_q);
        default: d_out = '0;
      endcase
    end else begin
      d_out = '0;
    end
  end

  // Next-state for both buffers, sticky flags and counters.
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    in_ovf_d   = in_ovf_q;
    rx_cnt_d   = rx_cnt_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    out_ovf_d  = out_ovf_q;
    tx_cnt_d   = tx_cnt_q;

    // Inbound: capture only when empty; a PE read of addr 0 can only clear a
    // full buffer, so capture and drain never coincide (no flow-through).
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
      rx_cnt_d  = rx_cnt_q + 8'd1;
    end else if (pe_rd_s && (addr == 2'd0) && in_full_q) begin
      in_full_d = 1'b0;
    end else begin
      in_full_d = in_full_q;
    end

    // Sticky inbound overflow: a new overflow beats a status-read clear.
    if (net_si && in_full_q) begin
      in_ovf_d = 1'b1;
    end else if (pe_rd_s && (addr == 2'd1)) begin
      in_ovf_d = 1'b0;
    end else begin
      in_ovf_d = in_ovf_q;
    end

    // Outbound: a write lands only into a buffer that was empty before the
    // edge, so a write in the release cycle is dropped as an overflow.
    if (pe_wr_s && (addr == 2'd2) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end else if (net_so) begin
      out_full_d = 1'b0;
      tx_cnt_d   = tx_cnt_q + 8'd1;
    end else begin
      out_full_d = out_full_q;
    end

    if (pe_wr_s && (addr == 2'd2) && out_full_q) begin
      out_ovf_d = 1'b1;
    end else if (pe_rd_s && (addr == 2'd3)) begin
      out_ovf_d = 1'b0;
    end else begin
      out_ovf_d = out_ovf_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      in_ovf_q   <= 1'b0;
      rx_cnt_q   <= 8'd0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      tx_cnt_q   <= 8'd0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      in_ovf_q   <= in_ovf_d;
      rx_cnt_q   <= rx_cnt_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      out_ovf_q  <= out_ovf_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
`timescale 1ns/1ps
module tb_cardinal_nic;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out, net_di, net_do;
  logic          nic_en, nic_wr_en, net_polarity, net_si, net_ri, net_so, net_ro;

  int checks = 0;
  int errors = 0;

  // Reference model: each single-entry buffer is a queue of at most one packet.
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  int            rx_m, tx_m;
  bit            in_ovf_m, out_ovf_m;
  logic [DW-1:0] e_dout, e_do;
  logic          e_ri, e_so;

  always #5 clk = ~clk;

  cardinal_nic #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en), .net_polarity(net_polarity),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di), .net_so(net_so),
    .net_ro(net_ro), .net_do(net_do)
  );

  task automatic model_reset();
    in_q.delete();
    out_q.delete();
    rx_m = 0; tx_m = 0; in_ovf_m = 1'b0; out_ovf_m = 1'b0;
  endtask

  task automatic model_outputs();
    e_ri = (in_q.size() == 0);
    e_so = 1'b0;
    e_do = '0;
    if (out_q.size() != 0) begin
      e_do = out_q[0];
      e_so = net_ro && (out_q[0][DW-1] == net_polarity);
    end
    e_dout = '0;
    if (nic_en && !nic_wr_en) begin
      case (addr)
        2'd0: if (in_q.size() != 0) e_dout = in_q[0];
        2'd1: e_dout = {48'd0, 8'(rx_m), 6'd0, in_ovf_m, (in_q.size() != 0)};
        2'd3: e_dout = {48'd0, 8'(tx_m), 6'd0, out_ovf_m, (out_q.size() != 0)};
        default: e_dout = '0;
      endcase
    end
  endtask

  // Applies the clock-edge rules to the model using the pre-edge state.
  task automatic model_edge();
    bit in_full_pre, out_full_pre, so, rd, wr;
    in_full_pre  = (in_q.size() != 0);
    out_full_pre = (out_q.size() != 0);
    so = out_full_pre && net_ro && (out_q[0][DW-1] == net_polarity);
    rd = nic_en && !nic_wr_en;
    wr = nic_en && nic_wr_en;
    if (net_si && !in_full_pre) begin
      in_q.push_back(net_di);
      rx_m = (rx_m + 1) % 256;
    end
    if (rd && addr == 2'd0 && in_full_pre) void'(in_q.pop_front());
    if (net_si && in_full_pre) in_ovf_m = 1'b1;
    else if (rd && addr == 2'd1) in_ovf_m = 1'b0;
    if (so) begin
      void'(out_q.pop_front());
      tx_m = (tx_m + 1) % 256;
    end
    if (wr && addr == 2'd2 && !out_full_pre) out_q.push_back(d_in);
    if (wr && addr == 2'd2 && out_full_pre) out_ovf_m = 1'b1;
    else if (rd && addr == 2'd3) out_ovf_m = 1'b0;
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] a,
                       input logic [DW-1:0] din, input logic si, input logic [DW-1:0] di,
                       input logic pol, input logic ro);
    nic_en = en; nic_wr_en = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_polarity = pol; net_ro = ro;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] pkt;
    idle();
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri got %b exp 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so got %b exp 0", net_so); end
    checks++; if (net_do !== '0) begin errors++; $display("FAIL reset_do got %h exp 0", net_do); end
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", d_out); end
    @(negedge clk);
    // Fill the outbound buffer, then hit reset while the packet is being offered.
    pkt = {1'b0, 63'($urandom) ^ 63'h1234};
    drive(1'b1, 1'b1, 2'd2, pkt, 1'b1, 64'h55, 1'b1, 1'b0);
    tick();
    idle(); net_polarity = 1'b0; net_ro = 1'b1;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL prereset_so got %b exp 1", net_so); end
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL async_so got %b exp 0", net_so); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL async_ri got %b exp 1", net_ri); end
    checks++; if (net_do !== '0) begin errors++; $display("FAIL async_do got %h exp 0", net_do); end
    drive(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    checks++; if (d_out !== '0) begin errors++; $display("FAIL async_st1 got %h exp 0", d_out); end
    addr = 2'd3;
    #1;
    checks++; if (d_out !== '0) begin errors++; $display("FAIL async_st3 got %h exp 0", d_out); end
    @(negedge clk);
    idle();
    reset = 1'b1;
  endtask

  task automatic test_inbound();
    drive(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_ri_pre got %b exp 1", net_ri); end
    tick();
    idle();
    #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL in_ri_full got %b exp 0", net_ri); end
    tick();
    drive(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (d_out !== 64'h0101) begin errors++; $display("FAIL in_status got %h exp %h", d_out, 64'h0101); end
    tick();
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (d_out !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL in_data got %h exp 0123456789abcdef", d_out); end
    tick();
    idle();
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_ri_post got %b exp 1", net_ri); end
    tick();
  endtask

  task automatic test_outbound_vc();
    int sends;
    drive(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_00AA, 1'b0, '0, 1'b0, 1'b1);
    tick();
    sends = 0;
    for (int c = 0; c < 4; c++) begin
      idle(); net_ro = 1'b1; net_polarity = c[0];
      #1;
      checks++;
      if (net_so !== ((c == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL vc_so cyc%0d got %b exp %b", c, net_so, (c == 1)); end
      if (c == 1) begin
        checks++;
        if (net_do !== 64'h8000_0000_0000_00AA) begin errors++; $display("FAIL vc_do got %h exp 80000000000000aa", net_do); end
      end
      tick();
    end
    drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (d_out[15:8] !== 8'd1) begin errors++; $display("FAIL vc_txcnt got %0d exp 1", d_out[15:8]); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pkt;
    pkt = {1'b0, 31'($urandom), 32'($urandom)};
    drive(1'b1, 1'b1, 2'd2, pkt, 1'b0, '0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      idle(); net_polarity = 1'b0; net_ro = 1'b0;
      #1;
      checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL bp_so cyc%0d got %b exp 0", c, net_so); end
      checks++; if (net_do !== pkt) begin errors++; $display("FAIL bp_hold got %h exp %h", net_do, pkt); end
      tick();
    end
    drive(1'b1, 1'b1, 2'd2, ~pkt, 1'b0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
    #1; model_outputs();
    checks++; if (d_out !== e_dout || d_out[1:0] !== 2'b11) begin errors++; $display("FAIL bp_st1 got %h exp %h", d_out, e_dout); end
    tick();
    drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
    #1; model_outputs();
    checks++; if (d_out !== e_dout || d_out[1:0] !== 2'b01) begin errors++; $display("FAIL bp_st2 got %h exp %h", d_out, e_dout); end
    tick();
    idle(); net_ro = 1'b1; net_polarity = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1 || net_do !== pkt) begin errors++; $display("FAIL bp_release got so=%b do=%h exp 1 %h", net_so, net_do, pkt); end
    tick();
    idle();
  endtask

  task automatic test_in_overflow();
    logic [DW-1:0] a, b;
    int rx0;
    a = {32'($urandom), 32'($urandom)};
    b = ~a;
    rx0 = rx_m;
    drive(1'b0, 1'b0, 2'd0, '0, 1'b1, a, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, '0, 1'b1, b, 1'b0, 1'b0);
    #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL ovf_ri got %b exp 0", net_ri); end
    tick();
    drive(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if (d_out !== {48'd0, 8'(rx0 + 1), 8'h03}) begin errors++; $display("FAIL ovf_status got %h exp %h", d_out, {48'd0, 8'(rx0 + 1), 8'h03}); end
    tick();
    drive(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (d_out !== a) begin errors++; $display("FAIL ovf_data got %h exp %h", d_out, a); end
    tick();
    idle();
  endtask

  task automatic test_counter_wrap();
    logic [DW-1:0] p, q;
    do_reset();
    for (int k = 0; k < 257; k++) begin
      p = {1'b0, 31'($urandom), 32'($urandom)};
      q = {32'($urandom), 32'($urandom)};
      drive(1'b1, 1'b1, 2'd2, p, 1'b1, q, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b1);
      #1;
      checks++;
      if (d_out !== q || net_so !== 1'b1 || net_do !== p) begin
        errors++; $display("FAIL wrap_xfer %0d got d=%h so=%b do=%h exp %h 1 %h", k, d_out, net_so, net_do, q, p);
      end
      tick();
      if (k >= 255) begin
        drive(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        checks++; if (d_out[15:8] !== 8'(k - 255)) begin errors++; $display("FAIL wrap_rx %0d got %0d exp %0d", k, d_out[15:8], k - 255); end
        tick();
        drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        checks++; if (d_out[15:8] !== 8'(k - 255)) begin errors++; $display("FAIL wrap_tx %0d got %0d exp %0d", k, d_out[15:8], k - 255); end
        tick();
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            {32'($urandom), 32'($urandom)}, ($urandom_range(0, 2) == 0),
            {32'($urandom), 32'($urandom)}, $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
      #1;
      model_outputs();
      checks++;
      if (d_out !== e_dout || net_ri !== e_ri || net_so !== e_so || net_do !== e_do) begin
        errors++;
        $display("FAIL rand cyc%0d got d=%h ri=%b so=%b do=%h exp d=%h ri=%b so=%b do=%h",
                 c, d_out, net_ri, net_so, net_do, e_dout, e_ri, e_so, e_do);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_inbound();
    test_outbound_vc();
    test_backpressure();
    test_in_overflow();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
